// File: rtl/calc_sequencer.sv
// Initiator-side driver for the two-flop FSM calculator: replays one command onto x/s, returns y.
// Optional build macro CALC_SYNC_CHECK_EN adds calculator-state tracking, a sticky err flag and RECOVER.
module calc_sequencer #(
    parameter int RES_HOLD = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] op,
    input  logic [4:0] a,
    input  logic [4:0] b,
    output logic       busy,
    output logic       done,
    output logic [5:0] result,
    output logic [4:0] x,
    output logic       s,
    input  logic       calc_a,
    input  logic       calc_b,
    input  logic [5:0] y_in,
    output logic       err
);

`ifdef CALC_SYNC_CHECK_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_OP, ST_LDA, ST_LDB, ST_HOLD, ST_CAP, ST_DONE, ST_RECOVER
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_OP, ST_LDA, ST_LDB, ST_HOLD, ST_CAP, ST_DONE
    } state_t;
`endif

    localparam logic [1:0] OP_ILLEGAL = 2'b00;
    localparam logic [3:0] HOLD_LOAD  = 4'((RES_HOLD > 0) ? RES_HOLD - 1 : 0);

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_op;
    logic [4:0] r_a;
    logic [4:0] r_b;
    logic [3:0] r_hold_cnt;
    logic [5:0] r_result;
    logic       w_accept;
    logic       w_sync_loss;

    assign w_accept = (r_state == ST_IDLE) && start && (op != OP_ILLEGAL);
    assign result   = r_result;

    // NOTE: reset is synchronous and active-low, so it lives inside the clocked branch;
    // every sequential assignment is non-blocking so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_hold_cnt <= '0;
            r_result   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_LDB)
                r_hold_cnt <= HOLD_LOAD;
            else if (r_state == ST_HOLD && r_hold_cnt != 4'd0)
                r_hold_cnt <= r_hold_cnt - 4'd1;
            if (r_state == ST_CAP && !w_sync_loss)
                r_result <= y_in;
        end
    end

    // NOTE: the command registers carry no reset; they are only decoded onto x after
    // being loaded by an accepted start, so their power-up value is never visible.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op <= op;
            r_a  <= a;
            r_b  <= b;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_next = r_state;
        x      = '0;
        s      = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept)
                    w_next = ST_OP;
            end
            ST_OP: begin
                x      = {3'b000, r_op};
                s      = 1'b1;
                busy   = 1'b1;
                w_next = ST_LDA;
            end
            ST_LDA: begin
                x      = r_a;
                busy   = 1'b1;
                w_next = ST_LDB;
            end
            ST_LDB: begin
                x      = r_b;
                s      = 1'b1;
                busy   = 1'b1;
                w_next = (RES_HOLD > 0) ? ST_HOLD : ST_CAP;
            end
            ST_HOLD: begin
                s    = 1'b1;
                busy = 1'b1;
                if (r_hold_cnt == 4'd0)
                    w_next = ST_CAP;
            end
            ST_CAP: begin
                busy   = 1'b1;
                w_next = ST_DONE;
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
`ifdef CALC_SYNC_CHECK_EN
            ST_RECOVER: begin
                // Walk the calculator forward to 00: only 10 needs s=1 to advance.
                s = ({calc_a, calc_b} == 2'b10);
                if ({calc_a, calc_b} == 2'b00)
                    w_next = ST_IDLE;
            end
`endif
            default: w_next = ST_IDLE;
        endcase
`ifdef CALC_SYNC_CHECK_EN
        if (w_sync_loss)
            w_next = ST_RECOVER;
`endif
    end

`ifdef CALC_SYNC_CHECK_EN
    logic [1:0] w_exp_ab;
    logic       r_err;

    always_comb begin
        w_exp_ab = 2'b00;
        case (r_state)
            ST_LDA:          w_exp_ab = 2'b01;
            ST_LDB:          w_exp_ab = 2'b10;
            ST_HOLD, ST_CAP: w_exp_ab = 2'b11;
            default:         w_exp_ab = 2'b00;
        endcase
    end

    assign w_sync_loss = (r_state != ST_RECOVER) && ({calc_a, calc_b} != w_exp_ab);

    always_ff @(posedge clk) begin
        if (!reset)
            r_err <= 1'b0;
        else if (w_sync_loss)
            r_err <= 1'b1;
    end

    assign err = r_err;
`else
    logic w_unused_calc;

    assign w_unused_calc = calc_a ^ calc_b;
    assign w_sync_loss   = 1'b0;
    assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: two instances (RES_HOLD 0 and 2), each driving a
// behavioural calculator; expected cycle behaviour comes from a per-cycle timing table.
module tb_calc_sequencer;

    localparam int N = 2;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [1:0] op    = 2'b00;
    logic [4:0] a     = '0;
    logic [4:0] b     = '0;

    logic       busy_o[N];
    logic       done_o[N];
    logic       s_o[N];
    logic       err_o[N];
    logic [5:0] result_o[N];
    logic [5:0] y_o[N];
    logic [4:0] x_o[N];

    // Behavioural calculator state per instance
    logic [1:0] cst[N];
    logic [1:0] cop[N];
    logic [4:0] cin1[N];
    logic [4:0] cin2[N];
    logic       inj_en  = 1'b0;
    logic [1:0] inj_val = 2'b00;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [5:0] prev_result[N];
    logic       exp_err[N];

    always #5 clk = ~clk;

    calc_sequencer #(.RES_HOLD(0)) u_dut0 (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy_o[0]), .done(done_o[0]), .result(result_o[0]),
        .x(x_o[0]), .s(s_o[0]), .calc_a(cst[0][1]), .calc_b(cst[0][0]),
        .y_in(y_o[0]), .err(err_o[0])
    );

    calc_sequencer #(.RES_HOLD(2)) u_dut2 (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy_o[1]), .done(done_o[1]), .result(result_o[1]),
        .x(x_o[1]), .s(s_o[1]), .calc_a(cst[1][1]), .calc_b(cst[1][0]),
        .y_in(y_o[1]), .err(err_o[1])
    );

    function automatic logic [5:0] calc_y(input logic [1:0] o, input logic [4:0] i1, input logic [4:0] i2);
        logic signed [9:0] e1, e2, r;
        e1 = 10'(signed'(i1));
        e2 = 10'(signed'(i2));
        case (o)
            2'b01:   r = e1 + e2;
            2'b10:   r = e1 - e2;
            2'b11:   r = e1 * e2;
            default: r = '0;
        endcase
        return r[5:0];
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (!reset)
                cst[i] <= 2'b00;
            else if (inj_en && i == 0)
                cst[i] <= inj_val;
            else begin
                case (cst[i])
                    2'b00: if (s_o[i])  begin cop[i]  <= x_o[i][1:0]; cst[i] <= 2'b01; end
                    2'b01: if (!s_o[i]) begin cin1[i] <= x_o[i];      cst[i] <= 2'b10; end
                    2'b10: if (s_o[i])  begin cin2[i] <= x_o[i];      cst[i] <= 2'b11; end
                    default: if (!s_o[i]) cst[i] <= 2'b00;
                endcase
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++)
            y_o[i] = calc_y(cop[i], cin1[i], cin2[i]);
    end

    // Reference arithmetic in plain integers, wrapped modulo 64
    function automatic logic [5:0] ref_result(input logic [1:0] o, input logic [4:0] ia, input logic [4:0] ib);
        int va, vb, r;
        va = ia[4] ? int'(ia) - 32 : int'(ia);
        vb = ib[4] ? int'(ib) - 32 : int'(ib);
        case (o)
            2'b01:   r = va + vb;
            2'b10:   r = va - vb;
            default: r = va * vb;
        endcase
        r = ((r % 64) + 64) % 64;
        return 6'(r);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // k = cycles since the accepting edge; k = 0 means idle with result held.
    task automatic check_cycle(input int k, input logic [1:0] o, input logic [4:0] ia, input logic [4:0] ib);
        for (int i = 0; i < N; i++) begin
            int         h;
            logic [4:0] ex;
            logic       es, eb, ed;
            logic [5:0] er;
            string      p;
            h  = (i == 0) ? 0 : 2;
            ex = '0; es = 1'b0; eb = 1'b0; ed = 1'b0;
            if (k == 1)                        begin ex = {3'b000, o}; es = 1'b1; eb = 1'b1; end
            else if (k == 2)                   begin ex = ia; eb = 1'b1; end
            else if (k == 3)                   begin ex = ib; es = 1'b1; eb = 1'b1; end
            else if (k >= 4 && k < 4 + h)      begin es = 1'b1; eb = 1'b1; end
            else if (k == 4 + h)               eb = 1'b1;
            else if (k == 5 + h)               ed = 1'b1;
            er = (k >= 5 + h) ? ref_result(o, ia, ib) : prev_result[i];
            p  = $sformatf("u%0d.c%0d.", i, k);
            check({p, "x"},      32'(x_o[i]),      32'(ex));
            check({p, "s"},      32'(s_o[i]),      32'(es));
            check({p, "busy"},   32'(busy_o[i]),   32'(eb));
            check({p, "done"},   32'(done_o[i]),   32'(ed));
            check({p, "result"}, 32'(result_o[i]), 32'(er));
            check({p, "err"},    32'(err_o[i]),    32'(exp_err[i]));
        end
    endtask

    task automatic run_cmd(input logic [1:0] co, input logic [4:0] ca, input logic [4:0] cb, input logic poke_busy);
        start = 1'b1; op = co; a = ca; b = cb;
        step();
        start = 1'b0; op = 2'($urandom); a = 5'($urandom); b = 5'($urandom);
        for (int k = 1; k <= 8; k++) begin
            check_cycle(k, co, ca, cb);
            if (poke_busy && k == 2) begin start = 1'b1; op = 2'($urandom_range(1, 3)); end
            if (k == 3) start = 1'b0;
            step();
        end
        for (int i = 0; i < N; i++) prev_result[i] = ref_result(co, ca, cb);
    endtask

    task automatic clear_expect();
        for (int i = 0; i < N; i++) begin
            prev_result[i] = '0;
            exp_err[i]     = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_expect();
        repeat (3) step();
        check_cycle(0, 2'b00, '0, '0);
        reset = 1'b1;
        step();
        check_cycle(0, 2'b00, '0, '0);

        run_cmd(2'b01, 5'd5,  5'd3,       1'b0);
        run_cmd(2'b10, 5'd3,  5'd5,       1'b0);
        run_cmd(2'b11, 5'd7,  5'b11100,   1'b0);
        run_cmd(2'b11, 5'd15, 5'd15,      1'b1);
        run_cmd(2'b10, 5'b10000, 5'd15,   1'b0);

        // Illegal opcode is ignored entirely
        start = 1'b1; op = 2'b00; a = 5'd9; b = 5'd9;
        step();
        start = 1'b0;
        repeat (3) begin
            check_cycle(0, 2'b00, '0, '0);
            step();
        end

        repeat (24)
            run_cmd(2'($urandom_range(1, 3)), 5'($urandom), 5'($urandom), 1'($urandom));

        // Reset during LDB aborts the command and clears result
        start = 1'b1; op = 2'b11; a = 5'd6; b = 5'd5;
        step();
        start = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            check_cycle(k, 2'b11, 5'd6, 5'd5);
            if (k < 3) step();
        end
        reset = 1'b0;
        step();
        clear_expect();
        check_cycle(0, 2'b00, '0, '0);
        reset = 1'b1;
        step();
        check_cycle(0, 2'b00, '0, '0);
        run_cmd(2'b01, 5'd10, 5'b10100, 1'b0);

        // Force the first calculator out of step while its sequencer is idle
        inj_val = 2'b01; inj_en = 1'b1;
        step();
        inj_en = 1'b0;
`ifdef CALC_SYNC_CHECK_EN
        check("sync.c0.s",   32'(s_o[0]),   32'd0);
        check("sync.c0.err", 32'(err_o[0]), 32'd0);
        step();
        check("sync.c1.s",   32'(s_o[0]),   32'd1);
        check("sync.c1.err", 32'(err_o[0]), 32'd1);
        step();
        check("sync.c2.s",   32'(s_o[0]),   32'd0);
        check("sync.c2.err", 32'(err_o[0]), 32'd1);
        step();
        check("sync.c3.calc", 32'(cst[0]),   32'd0);
        check("sync.c3.done", 32'(done_o[0]), 32'd0);
        step();
        step();
        exp_err[0] = 1'b1;
        run_cmd(2'b11, 5'd3, 5'b11011, 1'b0);
`else
        repeat (3) begin
            check("nosync.err", 32'(err_o[0]), 32'd0);
            step();
        end
`endif
        reset = 1'b0;
        step();
        reset = 1'b1;
        clear_expect();
        step();
        check_cycle(0, 2'b00, '0, '0);
        run_cmd(2'b01, 5'd1, 5'd2, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Initiator-side driver for the two-flop FSM calculator. Accepts one operation command (opcode plus two signed 5-bit operands) through a start/busy/done handshake and replays it onto the calculator's `x`/`s` entry interface at the rate the calculator expects. It captures the calculator's 6-bit `y` result and returns it to the requester. It sits between a host/test controller and the calculator instance, sharing that instance's clock and reset.

## Interface
- `RES_HOLD`, default 0: extra cycles the calculator is held in its result state (`s`=1) before `y` is captured; legal range 0–15.
- `clk` input 1: clock, shared with the calculator.
- `reset` input 1: synchronous, active-low; shared with the calculator.
- `start` input 1: command request, sampled in IDLE only.
- `op` input 2: 01 add, 10 subtract, 11 multiply; 00 is illegal.
- `a` input 5: signed operand In1.
- `b` input 5: signed operand In2.
- `busy` output 1: high from the cycle after an accepted `start` until `done`.
- `done` output 1: one-cycle pulse; `result` is valid from this cycle on.
- `result` output 6: captured `y`; held until the next capture.
- `x` output 5: calculator operand/opcode bus.
- `s` output 1: calculator step input.
- `calc_a` input 1: calculator `A_out`.
- `calc_b` input 1: calculator `B_out`.
- `y_in` input 6: calculator `y`.
- `err` output 1: sticky sync-loss flag, cleared by reset only.

## Operation
- Reset values: state IDLE; `busy`=0, `done`=0, `result`=0, `x`=0, `s`=0, `err`=0.
- The command (`op`, `a`, `b`) is registered on acceptance. `x` and `s` are Moore outputs decoded from the state register.
- Calculator transitions relied on ({A,B}, s → next):
  - 00: s=1 → 01.
  - 01: s=0 → 10.
  - 10: s=1 → 11; s=0 → 10.
  - 11: s=1 → 11; s=0 → 00.
- States, with drive and expected calculator state:
  - IDLE: `x`=0, `s`=0; calculator 00. `start`=1 with `op`≠00 → OP. `start` with `op`=00 is ignored; no busy, no done.
  - OP: `x`={3'b000,op}, `s`=1; calculator 00 (op latched) → LDA.
  - LDA: `x`=a, `s`=0; calculator 01 (In1 loaded) → LDB.
  - LDB: `x`=b, `s`=1; calculator 10 (In2 loaded) → HOLD if `RES_HOLD`>0, else CAP.
  - HOLD: `x`=0, `s`=1, for `RES_HOLD` cycles; calculator 11 → CAP.
  - CAP: `x`=0, `s`=0; calculator 11. `y_in` registered into `result` at the closing edge; calculator returns to 00 → DONE.
  - DONE: `done`=1, `x`=0, `s`=0; calculator 00 → IDLE.
- `start` outside IDLE is ignored; there is no queueing.
- Arithmetic is performed entirely by the calculator. `result` is its 6-bit two's-complement output, truncated as the calculator produces it. No saturation.
- Reset mid-operation returns both blocks to IDLE/00. No `done` is issued for the aborted command.

## Timing
- `start` sampled at edge 0 → OP at cycle 1, LDA 2, LDB 3, CAP 4+`RES_HOLD`, `done` at cycle 5+`RES_HOLD`.
- `busy` is high in cycles 1 through 4+`RES_HOLD` and low in the DONE cycle.
- The earliest next `start` is sampled in the cycle after DONE. Minimum command period is 6+`RES_HOLD` cycles.

## Configuration
- `CALC_SYNC_CHECK_EN` defined:
  - Each cycle, {`calc_a`,`calc_b`} is compared with the expected calculator state listed above.
  - On mismatch: set `err`, abandon the command (no `done`), and enter RECOVER.
  - RECOVER: `x`=0; `s`=1 when calculator reads 10, else `s`=0. Exit to IDLE when calculator reads 00. Worst case is 3 cycles (01→10→11→00).
- Not defined:
  - `calc_a`/`calc_b` are ignored and `err` is tied to 0.
  - No RECOVER state exists.

## Test plan
- `op`=01, a=5, b=3, `RES_HOLD`=0 → x/s sequence (1,1),(5,0),(3,1),(0,0); `done` at cycle 5; `result`=6'b001000.
- `op`=10, a=3, b=5 → `result`=6'b111110 (−2). `op`=11, a=7, b=−4 → 6'b100100 (−28 truncated).
- `RES_HOLD`=2, `op`=11, a=15, b=15 → `s`=1 for cycles 4–5, `done` at cycle 7, `result`=6'b100001.
- `start` with `op`=00, and `start` during `busy` → both ignored; no state change, no `done`.
- `reset` low during LDB → next cycle IDLE, `busy`=0, `result` cleared to 0; a following add runs normally.
- With `CALC_SYNC_CHECK_EN`, force calculator to 01 while the sequencer is in IDLE → `err`=1; s pattern 0,1,0; calculator reaches 00; IDLE in ≤3 cycles; `err` stays high until reset.
